// File: rtl/fifo_stream_pkg.sv
// Shared state encoding, buffer sizing and pointer helper for the FIFO-to-stream pop engine.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry in-order skid buffer between the FIFO read port and the stream output.
module stream_out_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full buffer still accepts a write when the head leaves in the same cycle.
    do_push  = push && ((count_q != CNT_W'(BUF_DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_pop_streamer.sv
// Drains LEN words from a FIFO with a one-cycle read latency and emits them as an AXI4-Stream packet.
module fifo_pop_streamer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [LEN_WIDTH-1:0]  LEN,
  output logic                  BUSY,
  output logic                  DONE,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_POP_REQ,
  input  logic [DATA_WIDTH-1:0] FIFO_POP_DATA,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TLAST
);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] pops_left_q, pops_left_d;
  logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_W-1:0]     buf_count;
  logic [DATA_WIDTH-1:0] head_data;
  logic                 beat;
  logic                 pop_req;

  assign beat = M_TVALID && M_TREADY;

  always_comb begin
    state_d      = state_q;
    pops_left_d  = pops_left_q;
    beats_left_d = beats_left_q;
    // Words in the buffer plus the one still on the FIFO read bus must never exceed the buffer.
    pop_req      = (state_q == ST_RUN) && !FIFO_EMPTY && (pops_left_q != '0) &&
                   (({1'b0, buf_count} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
    inflight_d   = pop_req;
    if (pop_req) pops_left_d = pops_left_q - LEN_WIDTH'(1);
    if (beat)    beats_left_d = beats_left_q - LEN_WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          pops_left_d  = LEN;
          beats_left_d = LEN;
          state_d      = (LEN == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN:  if (beat && (beats_left_q == LEN_WIDTH'(1))) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      pops_left_q  <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pops_left_q  <= pops_left_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
    end
  end

  stream_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .srst      (RESET),
    .push      (inflight_q),
    .push_data (FIFO_POP_DATA),
    .pop       (beat),
    .count     (buf_count),
    .head_data (head_data)
  );

  assign FIFO_POP_REQ = pop_req;
  assign BUSY         = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign DONE         = (state_q == ST_FIN);
  assign M_TVALID     = (buf_count != '0);
  // Gate the head so uninitialised buffer storage never reaches the bus.
  assign M_TDATA      = M_TVALID ? head_data : '0;
  assign M_TLAST      = M_TVALID && (beats_left_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Directed and randomized bench for fifo_pop_streamer with a queue-based FIFO and stream scoreboard.
module tb_fifo_pop_streamer;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, pop_req, tvalid, tlast;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] pop_data = '0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;

  fifo_pop_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK(clk), .RESET(rst), .START(start), .LEN(len), .BUSY(busy), .DONE(done),
    .FIFO_EMPTY(fifo_empty), .FIFO_POP_REQ(pop_req), .FIFO_POP_DATA(pop_data),
    .M_TVALID(tvalid), .M_TREADY(tready), .M_TDATA(tdata), .M_TLAST(tlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            block_cycles = 0;
  bit            rand_empty = 1'b0;
  bit            active = 1'b0;
  bit            done_due = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] tdata_prev = '0;
  int            len_cur = 0;
  int            beats_seen = 0;
  int            pops_seen = 0;
  int            cyc = 0;
  int            first_hs = -1;
  int            last_hs = -1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    bit rnd_blk;
    rnd_blk = rand_empty && ($urandom_range(0, 2) == 0);
    fifo_empty = (block_cycles > 0) || rnd_blk || (fifo_q.size() == 0);
  endtask

  task automatic load(input int n, input bit rnd, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = rnd ? $urandom : base + DW'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    upd_empty();
  endtask

  // One clock: check at the falling edge, then apply FIFO effects just after the rising edge.
  task automatic tick();
    bit pop_s, hs_s, exp_done, accept;
    @(negedge clk);
    pop_s  = pop_req;
    hs_s   = tvalid && tready;
    accept = start && !active;
    if (stall_prev) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_data", tdata, tdata_prev);
    end
    if (pop_s) begin
      chk("pop_while_empty", fifo_empty, 0);
      chk("pop_outstanding_lt3", (pops_seen - beats_seen) < 3, 1);
      chk("pop_within_len", pops_seen < len_cur, 1);
    end
    if (!active) chk("idle_valid", tvalid, 0);
    if (hs_s) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat_data", tdata, exp_q.pop_front());
      chk("beat_last", tlast, beats_seen == len_cur - 1);
      beats_seen++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    exp_done = done_due;
    done_due = 1'b0;
    chk("busy", busy, active);
    chk("done", done, exp_done);
    if (exp_done) active = 1'b0;
    if (hs_s && beats_seen == len_cur) done_due = 1'b1;
    if (accept) begin
      active     = 1'b1;
      len_cur    = int'(len);
      beats_seen = 0;
      pops_seen  = 0;
      first_hs   = -1;
      last_hs    = -1;
      if (len == '0) done_due = 1'b1;
    end
    stall_prev = tvalid && !tready;
    tdata_prev = tdata;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s && fifo_q.size() > 0) pop_data = fifo_q.pop_front();
    if (pop_s) pops_seen++;
    if (block_cycles > 0) block_cycles--;
    upd_empty();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    block_cycles = 0;
    rand_empty = 1'b0;
    upd_empty();
    active = 1'b0;
    done_due = 1'b0;
    stall_prev = 1'b0;
    len_cur = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop_req", pop_req, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low 5 cycles after 2 beats.
  task automatic xfer(input int n, input int mode, input int stop_after, input int restart_at);
    int stall_done;
    stall_done = 0;
    len    = LW'(n);
    start  = 1'b1;
    tready = (mode != 1) || ($urandom_range(0, 1) == 1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000 && active; c++) begin
      if (stop_after > 0 && beats_seen >= stop_after) return;
      case (mode)
        0: tready = 1'b1;
        1: tready = ($urandom_range(0, 3) != 0);
        default: begin
          if (beats_seen >= 2 && stall_done < 5) begin
            tready = 1'b0;
            stall_done++;
          end else begin
            tready = 1'b1;
          end
        end
      endcase
      start = (c == restart_at);
      len   = LW'($urandom_range(1, 50));
      tick();
      start = 1'b0;
    end
    chk("xfer_complete", active, 0);
    chk("beat_count", beats_seen, n);
  endtask

  initial begin
    do_reset();

    load(8, 1'b0, 32'h1);
    xfer(8, 0, 0, -1);
    chk("consecutive_beats", last_hs - first_hs, 7);
    tick();

    xfer(0, 0, 0, -1);
    chk("len0_no_pops", pops_seen, 0);

    load(6, 1'b1, '0);
    xfer(6, 2, 0, -1);

    block_cycles = 5;
    load(2, 1'b0, 32'hA);
    xfer(2, 0, 0, -1);

    load(10, 1'b1, '0);
    xfer(10, 0, 3, -1);
    do_reset();
    load(2, 1'b1, '0);
    xfer(2, 0, 0, -1);

    load(5, 1'b1, '0);
    xfer(5, 0, 0, 3);

    rand_empty = 1'b1;
    for (int t = 0; t < 15; t++) begin
      int n;
      n = $urandom_range(1, 25);
      load(n, 1'b1, '0);
      xfer(n, 1, 0, $urandom_range(0, 10));
    end
    rand_empty = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
